mem: RTL

Memory-access stage of the b-risc pipeline, sitting between execute and writeback. It registers the execute-stage bundle, performs loads and stores on a single-outstanding data-memory port with a req/ack handshake, and stalls upstream while an access is pending. It hands writeback a bundle in which a completed load appears as `DEST_SRC_ALU` with the loaded, extended word on the ALU-result lane. Writeback therefore needs no memory path.

---
 rtl/mem.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem.sv
// mem: memory-access pipeline stage; registers the execute bundle and runs loads/stores
// over a single-outstanding req/ack data port, stalling upstream while waiting.
module mem #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32,
    parameter int INSTR_W = 32,
    parameter int REG_IDX_W = 5,
    parameter int DEST_SRC_W = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter logic [DEST_SRC_W-1:0] DEST_SRC_NONE = DEST_SRC_W'(0),
    parameter logic [DEST_SRC_W-1:0] DEST_SRC_ALU = DEST_SRC_W'(1)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic [INSTR_W-1:0]    i_instr,
    input  logic [DEST_SRC_W-1:0] i_dest_src,
    input  logic [REG_IDX_W-1:0]  i_dest_reg,
    input  logic [WORD_W-1:0]     i_alu_eval,
    input  logic [1:0]            i_mem_op,
    input  logic [1:0]            i_mem_size,
    input  logic                  i_mem_unsigned,
    input  logic [WORD_W-1:0]     i_store_data,
    output logic                  o_stall,
    output logic [ADDR_W-1:0]     o_pc,
    output logic [INSTR_W-1:0]    o_instr,
    output logic [DEST_SRC_W-1:0] o_dest_src,
    output logic [REG_IDX_W-1:0]  o_dest_reg,
    output logic [WORD_W-1:0]     o_alu_eval,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [ADDR_W-1:0]     o_dmem_addr,
    output logic [WORD_W-1:0]     o_dmem_wdata,
    output logic [3:0]            o_dmem_be,
    input  logic                  i_dmem_ack,
    input  logic [WORD_W-1:0]     i_dmem_rdata,
    output logic                  o_misalign,
    output logic                  o_bus_err
);
    typedef enum logic {S_PASS, S_ACCESS} state_t;

    state_t                  state, state_nx;
    logic [7:0]              cnt;
    logic [ADDR_W-1:0]       r_pc;
    logic [INSTR_W-1:0]      r_instr;
    logic [DEST_SRC_W-1:0]   r_dest_src;
    logic [REG_IDX_W-1:0]    r_dest_reg;
    logic [WORD_W-1:0]       r_alu_eval;
    logic [1:0]              r_mem_op;
    logic [1:0]              r_mem_size;
    logic                    r_mem_unsigned;
    logic [WORD_W-1:0]       r_store_data;
    logic                    acc, ld, st, mis, timeout, done, sx, in_mem;
    logic [1:0]              a;
    logic [7:0]              lb;
    logic [15:0]             lh;
    logic [WORD_W-1:0]       ld_val;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        return (size == 2'b01 && addr[0]) || (size[1] && addr != 2'b00);
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_PASS;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pc           <= '0;
            r_instr        <= '0;
            r_dest_src     <= DEST_SRC_NONE;
            r_dest_reg     <= '0;
            r_alu_eval     <= '0;
            r_mem_op       <= '0;
            r_mem_size     <= '0;
            r_mem_unsigned <= 1'b0;
            r_store_data   <= '0;
            cnt            <= '0;
        end else if (!o_stall) begin
            r_pc           <= i_pc;
            r_instr        <= i_instr;
            r_dest_src     <= i_dest_src;
            r_dest_reg     <= i_dest_reg;
            r_alu_eval     <= i_alu_eval;
            r_mem_op       <= i_mem_op;
            r_mem_size     <= i_mem_size;
            r_mem_unsigned <= i_mem_unsigned;
            r_store_data   <= i_store_data;
            cnt            <= '0;
        end else begin
            cnt            <= cnt + 8'd1;
        end
    end

    always_comb begin
        a       = r_alu_eval[1:0];
        ld      = r_mem_op == 2'b01;
        st      = r_mem_op == 2'b10;
        mis     = misaligned(r_mem_size, a);
        acc     = state == S_ACCESS;
        done    = acc && i_dmem_ack;
        timeout = acc && !i_dmem_ack && cnt == 8'(TIMEOUT_CYC);
        o_stall = acc && !i_dmem_ack && !timeout;
        o_misalign = !acc && (ld || st) && mis;
        o_bus_err  = timeout;
        o_pc       = r_pc;
        o_instr    = r_instr;
        o_dest_reg = r_dest_reg;
        // load lane selection and extension
        sx      = !r_mem_unsigned;
        lb      = i_dmem_rdata[{a, 3'b000} +: 8];
        lh      = a[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        ld_val  = r_mem_size == 2'b00 ? {{(WORD_W-8){sx & lb[7]}}, lb} :
                  r_mem_size == 2'b01 ? {{(WORD_W-16){sx & lh[15]}}, lh} : i_dmem_rdata;
        o_dest_src = acc ? ((done && ld) ? DEST_SRC_ALU : DEST_SRC_NONE) :
                     ((ld || st) ? DEST_SRC_NONE : r_dest_src);
        o_alu_eval = (done && ld) ? ld_val : r_alu_eval;
        // request lanes derive only from registered state
        o_dmem_req   = acc;
        o_dmem_we    = acc && st;
        o_dmem_addr  = acc ? ADDR_W'({r_alu_eval[WORD_W-1:2], 2'b00}) : '0;
        o_dmem_be    = !acc ? 4'b0000 : r_mem_size == 2'b00 ? 4'b0001 << a :
                       r_mem_size == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        o_dmem_wdata = !acc ? '0 : r_mem_size == 2'b00 ? {4{r_store_data[7:0]}} :
                       r_mem_size == 2'b01 ? {2{r_store_data[15:0]}} : r_store_data;
        in_mem   = (i_mem_op == 2'b01 || i_mem_op == 2'b10) && !misaligned(i_mem_size, i_alu_eval[1:0]);
        state_nx = o_stall ? state : (in_mem ? S_ACCESS : S_PASS);
    end
endmodule
